// File: rtl/inst_trace_buffer_if.sv
// Capture/display handshake bundle for inst_trace_buffer.
// master: IF stage + display consumer side, slave: the trace buffer.
interface inst_trace_buffer_if #(
  parameter int SEQ_W = 16
);
  logic             cap_valid;
  logic [31:0]      cap_pc;
  logic [31:0]      cap_inst;
  logic             out_ready;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output cap_valid, cap_pc, cap_inst, out_ready,
    input  out_valid, out_pc, out_inst, out_seq
  );

  modport slave (
    input  cap_valid, cap_pc, cap_inst, out_ready,
    output out_valid, out_pc, out_inst, out_seq
  );
endinterface

// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: FIFO of {pc, inst, seq} between the fetch stage
// and a slow, back-pressured disassembler/debug printer. Fetch is never
// stalled; captures arriving while full are dropped and counted.
// Optional feature macro: TRACE_NOP_FILTER_EN (drop all-zero nop words
// before they reach the buffer).
module inst_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int SEQ_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_trace_buffer_if.slave   tif,
  input  logic                 flush,
  input  logic                 clr_ovf,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic [SEQ_W-1:0]     drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];
  logic [SEQ_W-1:0] mem_seq  [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [SEQ_W-1:0] seq;
  logic [AW:0]      count_nxt;

  logic             cap_eff;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             head_from_cap;
  logic             head_load;
  logic [31:0]      head_pc;
  logic [31:0]      head_inst;
  logic [SEQ_W-1:0] head_seq;

  // Qualify the capture strobe, optionally hiding nops from the buffer.
  always_comb begin
    cap_eff = tif.cap_valid;
`ifdef TRACE_NOP_FILTER_EN
    if (tif.cap_inst == 32'h0000_0000) begin
      cap_eff = 1'b0;
    end
`else
    cap_eff = tif.cap_valid;
`endif
  end

  // Push/pop/drop decisions; flush swallows any capture in the same cycle.
  always_comb begin
    full = (count == FULL_CNT);
    pop  = tif.out_valid & tif.out_ready;
    push = cap_eff & (~full | pop) & ~flush;
    drop = cap_eff & full & ~pop & ~flush;
  end

  // Next occupancy and next head location.
  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    if (pop) begin
      rd_ptr_nxt = rd_ptr + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_nxt = count + ONE_CNT;
      2'b01:   count_nxt = count - ONE_CNT;
      default: count_nxt = count;
    endcase
    if (flush) begin
      count_nxt = '0;
    end
  end

  // Choose what the registered head shows after this edge: the incoming
  // capture when it becomes the only entry, otherwise the stored slot.
  always_comb begin
    head_from_cap = push & ((count == '0) | ((count == ONE_CNT) & pop));
    head_load     = ~flush & (count_nxt != '0);
    head_pc       = mem_pc[rd_ptr_nxt];
    head_inst     = mem_inst[rd_ptr_nxt];
    head_seq      = mem_seq[rd_ptr_nxt];
    if (head_from_cap) begin
      head_pc   = tif.cap_pc;
      head_inst = tif.cap_inst;
      head_seq  = seq;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= tif.cap_pc;
      mem_inst[wr_ptr] <= tif.cap_inst;
      mem_seq[wr_ptr]  <= seq;
    end
  end

  // Pointers, occupancy and sequence tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr_nxt;
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (push) begin
        seq <= seq + 1'b1;
      end
    end
  end

  // Registered head presented to the consumer; held stable until popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tif.out_valid <= 1'b0;
      tif.out_pc    <= '0;
      tif.out_inst  <= '0;
      tif.out_seq   <= '0;
    end else begin
      tif.out_valid <= (count_nxt != '0);
      if (head_load) begin
        tif.out_pc   <= head_pc;
        tif.out_inst <= head_inst;
        tif.out_seq  <= head_seq;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; clear beats a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Self-checking bench for inst_trace_buffer: a scoreboard queue of expected
// head entries plus a small occupancy/overflow model.
module tb_inst_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic clr_ovf;
  logic [AW:0]      count;
  logic             overflow;
  logic [SEQ_W-1:0] drop_cnt;

  inst_trace_buffer_if #(.SEQ_W(SEQ_W)) tif ();

  inst_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .SEQ_W(SEQ_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tif      (tif.slave),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  entry_t           sb[$];
  logic [SEQ_W-1:0] m_seq;
  logic [SEQ_W-1:0] m_drop;
  logic             m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_eff(input logic cv, input logic [31:0] inst);
`ifdef TRACE_NOP_FILTER_EN
    return cv && (inst != 32'h0000_0000);
`else
    return cv && (inst == inst);
`endif
  endfunction

  task automatic checkOutput();
    chk("count", 64'(count), 64'(sb.size()));
    chk("out_valid", 64'(tif.out_valid), 64'(sb.size() != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (sb.size() != 0) begin
      chk("head_pc", 64'(tif.out_pc), 64'(sb[0].pc));
      chk("head_inst", 64'(tif.out_inst), 64'(sb[0].inst));
      chk("head_seq", 64'(tif.out_seq), 64'(sb[0].seq));
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, update the model, clock.
  task automatic applyStimulus(input logic cv, input logic [31:0] pc, input logic [31:0] inst,
                               input logic rdy, input logic fl, input logic clr);
    logic   eff;
    logic   mfull;
    logic   mpop;
    entry_t e;
    tif.cap_valid = cv;
    tif.cap_pc    = pc;
    tif.cap_inst  = inst;
    tif.out_ready = rdy;
    flush         = fl;
    clr_ovf       = clr;
    eff   = is_eff(cv, inst);
    mfull = (sb.size() == DEPTH);
    mpop  = (sb.size() != 0) && rdy;
    if (mpop) begin
      chk("pop_pc", 64'(tif.out_pc), 64'(sb[0].pc));
      chk("pop_inst", 64'(tif.out_inst), 64'(sb[0].inst));
      chk("pop_seq", 64'(tif.out_seq), 64'(sb[0].seq));
      void'(sb.pop_front());
    end
    if (fl) begin
      sb.delete();
    end else if (eff && (!mfull || mpop)) begin
      e.pc = pc; e.inst = inst; e.seq = m_seq;
      sb.push_back(e);
      m_seq = m_seq + 1'b1;
    end else if (eff && mfull && !mpop) begin
      m_ovf = 1'b1;
      if (m_drop != '1) m_drop = m_drop + 1'b1;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm outputs clear immediately.
  task automatic doReset();
    tif.cap_valid = 1'b0; tif.cap_pc = '0; tif.cap_inst = '0;
    tif.out_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(tif.out_valid), 64'd0);
    chk("rst_pc", 64'(tif.out_pc), 64'd0);
    chk("rst_inst", 64'(tif.out_inst), 64'd0);
    chk("rst_seq", 64'(tif.out_seq), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    sb.delete();
    m_seq = '0; m_drop = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    tif.cap_valid = 1'b0; tif.cap_pc = '0; tif.cap_inst = '0;
    tif.out_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    m_seq = '0; m_drop = '0; m_ovf = 1'b0;
    @(negedge clk);
    doReset();
    idle(1'b0);

    // Two captures with no consumer, then one pop.
    applyStimulus(1'b1, 32'h0, 32'h00084080, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 32'h25280005, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_inst", 64'(tif.out_inst), 64'h00084080);
    chk("t2_seq", 64'(tif.out_seq), 64'd0);
    idle(1'b1);
    chk("t2_pop_inst", 64'(tif.out_inst), 64'h25280005);
    chk("t2_pop_seq", 64'(tif.out_seq), 64'd1);
    chk("t2_pop_count", 64'(count), 64'd1);

    // Fill from a fresh reset, overflow by three, drain, then clear.
    doReset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      applyStimulus(1'b1, 32'(32'h1000 + 4 * i), $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_drop", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);
    chk("t3_empty", 64'(tif.out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 64'(drop_cnt), 64'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(32'h2000 + 4 * i), $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'h2FFC, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 64'(count), 64'd16);
    chk("t4_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < DEPTH; i++) idle(1'b1);

    // Clear wins over a drop in the same cycle.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(32'h3000 + 4 * i), $urandom | 32'h1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'h3FF0, 32'h11111111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3FF4, 32'h22222222, 1'b0, 1'b0, 1'b1);
    chk("clr_win_drop", 64'(drop_cnt), 64'd0);
    chk("clr_win_ovf", 64'(overflow), 64'd0);

    // Flush with capture in the same cycle; drop count untouched.
    applyStimulus(1'b1, 32'h3FF8, 32'h33333333, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4000, 32'h44444444, 1'b0, 1'b1, 1'b0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd1);
    applyStimulus(1'b1, 32'h4004, 32'h55555555, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Empty with push and ready in the same cycle.
    applyStimulus(1'b1, 32'h5000, 32'h66666666, 1'b1, 1'b0, 1'b0);
    chk("empty_push_count", 64'(count), 64'd1);
    idle(1'b1);

    // Mid-stream reset, then nop handling.
    applyStimulus(1'b1, 32'h6000, 32'h77777777, 1'b0, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 32'h100, 32'h00000000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 32'h03E00008, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
